// File: rtl/mouse_byte_receiver.sv
// -----------------------------------------------------------------------------
// mouse_byte_receiver
//
// PS/2 device-to-host byte receiver. Synchronizes the mouse clock and data
// lines into the CLK domain, detects falling edges of the mouse clock, and
// deframes each 11-bit PS/2 frame: start bit (0), eight data bits LSB first,
// an odd-parity bit and a stop bit (1). Each completed frame is presented
// with a one-cycle BYTE_READY strobe and a 2-bit error code. Frames that
// have a parity or stop-bit error are still delivered. The consumer decides
// what to do with them.
//
// A frame that stalls for longer than TIMEOUT_CYCLES between mouse-clock
// falling edges is abandoned without a strobe. This lets the receiver
// recover from a device that stops clocking partway through a frame.
//
// Parameters
//   TIMEOUT_CYCLES  max CLK cycles between mouse-clock falling edges in a frame
//
// Ports
//   CLK              in   system clock, all logic on posedge
//   RESET            in   synchronous active-high reset
//   CLK_MOUSE_IN     in   PS/2 clock line (asynchronous to CLK)
//   DATA_MOUSE_IN    in   PS/2 data line (asynchronous to CLK)
//   READ_ENABLE      in   a new frame may only begin while high
//   BYTE_READ        out  last received data byte
//   BYTE_ERROR_CODE  out  [0] parity error, [1] stop-bit error
//   BYTE_READY       out  one-cycle strobe, BYTE_READ/BYTE_ERROR_CODE valid
// -----------------------------------------------------------------------------
module mouse_byte_receiver #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    // -------------------------------------------------------------------------
    // Line synchronizers
    // -------------------------------------------------------------------------
    // Index 0 is the mouse clock and index 1 is the mouse data. Both lines go
    // through identical 2-flop chains. Because the latency is the same, a data
    // bit that is stable around a clock falling edge at the pins is still
    // aligned with that edge after synchronization.
    localparam int N_LINES = 2;
    localparam int LINE_CLK  = 0;
    localparam int LINE_DATA = 1;

    logic [N_LINES-1:0] line_pins;
    logic [N_LINES-1:0] line_sync;

    assign line_pins[LINE_CLK]  = CLK_MOUSE_IN;
    assign line_pins[LINE_DATA] = DATA_MOUSE_IN;

    generate
        for (genvar gi = 0; gi < N_LINES; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // The PS/2 lines idle high. The flops reset to 1 so that leaving
            // reset does not look like a falling edge.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= line_pins[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    logic mouse_clk_sync;
    logic mouse_data_sync;

    assign mouse_clk_sync  = line_sync[LINE_CLK];
    assign mouse_data_sync = line_sync[LINE_DATA];

    // -------------------------------------------------------------------------
    // Falling-edge detect on the synchronized mouse clock
    // -------------------------------------------------------------------------
    logic clk_prev_reg;
    logic fe;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= mouse_clk_sync;
        end
    end

    // High for exactly one CLK when the synchronized clock goes 1 -> 0.
    assign fe = clk_prev_reg & ~mouse_clk_sync;

    // -------------------------------------------------------------------------
    // Frame state machine
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // The counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    state_t          state_reg;
    logic [2:0]      bit_cnt_reg;
    logic [7:0]      shift_reg;
    logic            parity_reg;
    logic [TW-1:0]   timeout_reg;
    logic            timed_out;

    // The timeout only applies inside a frame. An edge in the same cycle as
    // the limit wins, so the frame keeps going.
    assign timed_out = (state_reg != ST_IDLE) && !fe &&
                       (timeout_reg == TIMEOUT_LIMIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 8'h00;
            parity_reg      <= 1'b0;
            timeout_reg     <= '0;
            BYTE_READ       <= 8'h00;
            BYTE_ERROR_CODE <= 2'b00;
            BYTE_READY      <= 1'b0;
        end else begin
            // The strobe is only raised by the stop-bit branch below.
            BYTE_READY <= 1'b0;

            if (timed_out) begin
                // Abandon the partial frame. The outputs keep the last
                // delivered byte.
                state_reg   <= ST_IDLE;
                timeout_reg <= '0;
            end else begin
                if (fe || (state_reg == ST_IDLE)) begin
                    timeout_reg <= '0;
                end else begin
                    timeout_reg <= timeout_reg + 1'b1;
                end

                case (state_reg)
                    ST_IDLE: begin
                        // READ_ENABLE gates only the start of a frame. After
                        // that the frame always runs to completion.
                        if (fe && READ_ENABLE && !mouse_data_sync) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= 3'd0;
                            shift_reg   <= 8'h00;
                        end
                    end

                    ST_DATA: begin
                        if (fe) begin
                            shift_reg[bit_cnt_reg] <= mouse_data_sync;
                            bit_cnt_reg            <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= ST_PARITY;
                            end
                        end
                    end

                    ST_PARITY: begin
                        if (fe) begin
                            parity_reg <= mouse_data_sync;
                            state_reg  <= ST_STOP;
                        end
                    end

                    ST_STOP: begin
                        if (fe) begin
                            BYTE_READ <= shift_reg;
                            // Odd parity: data bits plus the parity bit must
                            // contain an odd number of ones.
                            BYTE_ERROR_CODE[0] <= ~(^shift_reg ^ parity_reg);
                            // The stop bit must be 1.
                            BYTE_ERROR_CODE[1] <= ~mouse_data_sync;
                            BYTE_READY         <= 1'b1;
                            state_reg          <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
